vga_sprite_store: RTL and testbench

Parametrised, single-clock sprite memory for the VGA pipeline, with two ports. The Avalon-MM slave `s1` lets the Nios II load sprite pixel data. A pipelined pixel-fetch port serves the sprite renderer with unpacked palette indices, optional horizontal/vertical mirroring and a transparency flag. An optional second bank gives double buffering: the CPU writes the back bank while the renderer reads the front bank, and the banks swap on a frame boundary.

---
 rtl/vga_sprite_pkg.sv | 34 +++
 rtl/vga_sprite_dpram.sv | 41 ++++
 rtl/vga_sprite_store.sv | 159 +++++++++++++++
 tb/tb_vga_sprite_store.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_sprite_pkg.sv
// Shared widths, CSR bit layout and sizing helpers for the sprite store.
package vga_sprite_pkg;

    localparam int CSR_PENDING = 0;
    localparam int CSR_FRONT   = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ppw(input int pixel_bits);
        return 32 / pixel_bits;
    endfunction

    function automatic int depth(input int count, input int w,
                                 input int h, input int pixel_bits);
        return (count * w * h) / ppw(pixel_bits);
    endfunction

    function automatic int aw(input int count, input int w,
                              input int h, input int pixel_bits);
        return clog2(depth(count, w, h, pixel_bits)) + 1;
    endfunction

    function automatic int ram_aw(input int count, input int w,
                                  input int h, input int pixel_bits,
                                  input int banks);
        return clog2(banks * depth(count, w, h, pixel_bits));
    endfunction

endpackage

// File: rtl/vga_sprite_dpram.sv
// Single-clock dual-port RAM: port A 32-bit byte-masked read/write,
// port B read-only and read-first.
module vga_sprite_dpram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_a_we,
    input  logic [3:0]    i_a_be,
    input  logic [AW-1:0] i_a_addr,
    input  logic [31:0]   i_a_wdata,
    output logic [31:0]   o_a_rdata,
    input  logic          i_b_en,
    input  logic [AW-1:0] i_b_addr,
    output logic [31:0]   o_b_rdata
);

    logic [31:0] r_mem [2**AW];
    logic [31:0] r_a_q;
    logic [31:0] r_b_q;

    always_ff @(posedge clk) begin
        if (i_a_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_a_be[i]) begin
                    r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
                end
            end
        end
        r_a_q <= r_mem[i_a_addr];
    end

    always_ff @(posedge clk) begin
        if (i_b_en) begin
            r_b_q <= r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_q;
    assign o_b_rdata = r_b_q;

endmodule

// File: rtl/vga_sprite_store.sv
// Sprite memory with Avalon-MM load port, double-buffer swap and a
// two-cycle pixel-fetch pipeline with mirroring and transparency.
module vga_sprite_store
    import vga_sprite_pkg::*;
#(
    parameter int SPRITE_COUNT = 16,
    parameter int SPRITE_W     = 16,
    parameter int SPRITE_H     = 16,
    parameter int PIXEL_BITS   = 4,
    parameter int BANKS        = 2,
    parameter int TRANSPARENT  = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic [aw(SPRITE_COUNT, SPRITE_W, SPRITE_H, PIXEL_BITS)-1:0] address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    input  logic        frame_start,
    input  logic        pix_req,
    input  logic [clog2(SPRITE_COUNT):0]  pix_sprite,
    input  logic [clog2(SPRITE_W)-1:0]    pix_x,
    input  logic [clog2(SPRITE_H)-1:0]    pix_y,
    input  logic        pix_hflip,
    input  logic        pix_vflip,
    output logic        pix_valid,
    output logic [PIXEL_BITS-1:0] pix_data,
    output logic        pix_opaque
);

    localparam int AW  = aw(SPRITE_COUNT, SPRITE_W, SPRITE_H, PIXEL_BITS);
    localparam int WW  = AW - 1;
    localparam int RAW = ram_aw(SPRITE_COUNT, SPRITE_W, SPRITE_H,
                                PIXEL_BITS, BANKS);
    localparam int SB  = clog2(SPRITE_COUNT);
    localparam int XB  = clog2(SPRITE_W);
    localparam int YB  = clog2(SPRITE_H);
    localparam int LB  = clog2(ppw(PIXEL_BITS));
    localparam int PW  = SB + XB + YB;
    localparam logic [PIXEL_BITS-1:0] TP = PIXEL_BITS'(TRANSPARENT);

    logic           w_csr_sel;
    logic           w_wr;
    logic           w_rd;
    logic           w_back;
    logic [RAW-1:0] w_a_addr;
    logic [RAW-1:0] w_b_addr;
    logic [31:0]    w_a_q;
    logic [31:0]    w_b_q;
    logic [XB-1:0]  w_x;
    logic [YB-1:0]  w_y;
    logic [PW-1:0]  w_p;
    logic           w_in_range;
    logic [4:0]     w_shamt;
    logic [PIXEL_BITS-1:0] w_lane_px;

    logic           r_front;
    logic           r_pending;
    logic           r_rdv;
    logic           r_rd_mem;
    logic [31:0]    r_csr_q;
    logic           r_s1_valid;
    logic           r_s1_in_range;
    logic [LB-1:0]  r_s1_lane;
    logic           r_pix_valid;
    logic [PIXEL_BITS-1:0] r_pix_data;
    logic           r_pix_opaque;

    // A simultaneous read+write is treated as a write only.
    assign w_csr_sel = address[AW-1];
    assign w_wr      = chipselect & write;
    assign w_rd      = chipselect & read & ~write;
    assign w_back    = (BANKS == 2) ? ~r_front : 1'b0;
    assign w_a_addr  = RAW'({w_back, address[WW-1:0]});

    // Power-of-two dimensions make mirroring a bit inversion.
    assign w_x        = pix_hflip ? ~pix_x : pix_x;
    assign w_y        = pix_vflip ? ~pix_y : pix_y;
    assign w_p        = {pix_sprite[SB-1:0], w_y, w_x};
    assign w_in_range = ~pix_sprite[SB];
    assign w_b_addr   = RAW'({r_front, w_p[PW-1:LB]});

    assign w_shamt   = 5'(r_s1_lane) * 5'(PIXEL_BITS);
    assign w_lane_px = PIXEL_BITS'(w_b_q >> w_shamt);

    vga_sprite_dpram #(
        .AW (RAW)
    ) u_ram (
        .clk       (clk),
        .i_a_we    (w_wr & ~w_csr_sel),
        .i_a_be    (byteenable),
        .i_a_addr  (w_a_addr),
        .i_a_wdata (writedata),
        .o_a_rdata (w_a_q),
        .i_b_en    (pix_req & w_in_range),
        .i_b_addr  (w_b_addr),
        .o_b_rdata (w_b_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
        end else if (frame_start && r_pending) begin
            r_front   <= ~r_front;
            r_pending <= 1'b0;
        end else if (BANKS == 2 && w_wr && w_csr_sel
                     && writedata[CSR_PENDING]) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdv    <= 1'b0;
            r_rd_mem <= 1'b0;
            r_csr_q  <= '0;
        end else begin
            r_rdv    <= w_rd;
            r_rd_mem <= w_rd & ~w_csr_sel;
            r_csr_q  <= '0;
            if (w_rd && w_csr_sel) begin
                r_csr_q[CSR_PENDING] <= r_pending;
                r_csr_q[CSR_FRONT]   <= r_front;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_in_range <= 1'b0;
            r_s1_lane     <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= '0;
            r_pix_opaque  <= 1'b0;
        end else begin
            r_s1_valid    <= pix_req;
            r_s1_in_range <= w_in_range;
            r_s1_lane     <= w_p[LB-1:0];
            r_pix_valid   <= r_s1_valid;
            r_pix_data    <= (r_s1_valid && r_s1_in_range)
                             ? w_lane_px : '0;
            r_pix_opaque  <= r_s1_valid && r_s1_in_range
                             && (w_lane_px != TP);
        end
    end

    assign readdata      = r_rd_mem ? w_a_q : r_csr_q;
    assign readdatavalid = r_rdv;
    assign pix_valid     = r_pix_valid;
    assign pix_data      = r_pix_data;
    assign pix_opaque    = r_pix_opaque;

endmodule

// File: tb/tb_vga_sprite_store.sv
// Scoreboard bench for vga_sprite_store with default parameters.
module tb_vga_sprite_store;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  address;
    logic        chipselect, read, write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic        frame_start;
    logic        pix_req;
    logic [4:0]  pix_sprite;
    logic [3:0]  pix_x, pix_y;
    logic        pix_hflip, pix_vflip;
    logic        pix_valid;
    logic [3:0]  pix_data;
    logic        pix_opaque;

    always #5 clk = ~clk;

    vga_sprite_store dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .frame_start   (frame_start),
        .pix_req       (pix_req),
        .pix_sprite    (pix_sprite),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_hflip     (pix_hflip),
        .pix_vflip     (pix_vflip),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .pix_opaque    (pix_opaque)
    );

    typedef struct {
        logic [3:0] d;
        logic       o;
        int         c;
    } pix_t;

    typedef struct {
        logic [31:0] d;
        int          c;
    } rd_t;

    typedef struct {
        logic        rst, cs, rd, wr, fs, rq, hf, vf;
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [4:0]  s;
        logic [3:0]  x, y;
    } stim_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    pix_t pq[$];
    rd_t  rq[$];

    logic [31:0] mem [2][512];
    logic        m_front = 1'b0;
    logic        m_pend  = 1'b0;

    function automatic stim_t s_idle();
        stim_t s;
        s = '{default: '0};
        s.be = 4'hF;
        return s;
    endfunction

    function automatic stim_t s_wr(input logic [9:0] a,
                                   input logic [31:0] d,
                                   input logic [3:0] be);
        stim_t s;
        s = s_idle();
        s.cs = 1'b1; s.wr = 1'b1; s.a = a; s.wd = d; s.be = be;
        return s;
    endfunction

    function automatic stim_t s_rd(input logic [9:0] a);
        stim_t s;
        s = s_idle();
        s.cs = 1'b1; s.rd = 1'b1; s.a = a;
        return s;
    endfunction

    function automatic stim_t s_pix(input logic [4:0] sp,
                                    input logic [3:0] x,
                                    input logic [3:0] y,
                                    input logic hf, input logic vf);
        stim_t s;
        s = s_idle();
        s.rq = 1'b1; s.s = sp; s.x = x; s.y = y;
        s.hf = hf; s.vf = vf;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        reset       = s.rst;
        chipselect  = s.cs;
        read        = s.rd;
        write       = s.wr;
        address     = s.a;
        byteenable  = s.be;
        writedata   = s.wd;
        frame_start = s.fs;
        pix_req     = s.rq;
        pix_sprite  = s.s;
        pix_x       = s.x;
        pix_y       = s.y;
        pix_hflip   = s.hf;
        pix_vflip   = s.vf;
    endtask

    function automatic pix_t exp_pix(input int bank);
        pix_t e;
        int xx, yy, p;
        logic [31:0] w;
        e.c = 0;
        if (pix_sprite >= 16) begin
            e.d = 4'd0;
            e.o = 1'b0;
            return e;
        end
        xx = pix_hflip ? 15 - int'(pix_x) : int'(pix_x);
        yy = pix_vflip ? 15 - int'(pix_y) : int'(pix_y);
        p  = int'(pix_sprite) * 256 + yy * 16 + xx;
        w  = mem[bank][p / 8];
        e.d = 4'((w >> ((p % 8) * 4)) & 32'hF);
        e.o = (e.d != 4'd0);
        return e;
    endfunction

    // Pushes expectations from the inputs now driven, then clocks.
    task automatic tick();
        pix_t e;
        rd_t  r;
        logic f0, p0;
        int   bk;
        f0 = m_front;
        p0 = m_pend;
        bk = f0 ? 0 : 1;
        if (reset) begin
            pq.delete();
            rq.delete();
            m_front = 1'b0;
            m_pend  = 1'b0;
        end else begin
            if (pix_req) begin
                e = exp_pix(f0 ? 1 : 0);
                e.c = cyc;
                pq.push_back(e);
            end
            if (chipselect && read && !write) begin
                r.c = cyc;
                r.d = address[9] ? {30'b0, f0, p0} : mem[bk][address[8:0]];
                rq.push_back(r);
            end
            if (chipselect && write && !address[9]) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        mem[bk][address[8:0]][8*i +: 8] = writedata[8*i +: 8];
                    end
                end
            end
            if (frame_start && p0) begin
                m_front = ~f0;
                m_pend  = 1'b0;
            end else if (chipselect && write && address[9] && writedata[0]) begin
                m_pend = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rd_t r;
        stim_t s;
        apply(s_idle());
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({readdata, readdatavalid, pix_valid, pix_data, pix_opaque} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%h rdv=%b pv=%b pd=%h po=%b, want all 0",
                     readdata, readdatavalid, pix_valid, pix_data, pix_opaque);
        end
        s = s_rd(10'h200);
        apply(s);
        tick();
        apply(s_idle());
        checks++;
        if (readdatavalid !== 1'b1 || rq.size() == 0) begin
            errors++;
            $display("FAIL reset_csr: rdv=%b, want 1", readdatavalid);
        end else begin
            r = rq.pop_front();
            if (readdata !== r.d || r.d !== 32'h0) begin
                errors++;
                $display("FAIL reset_csr: rd=%h, want 00000000", readdata);
            end
        end
        tick();
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdv_once: rdv=%b, want 0", readdatavalid);
        end
    endtask

    task automatic test_pixel_map();
        stim_t tbl[$];
        stim_t s;
        pix_t  e;
        rd_t   r;
        tbl.push_back(s_wr(10'd0,  32'h76543210, 4'hF));
        tbl.push_back(s_wr(10'd1,  32'hA0000000, 4'hF));
        tbl.push_back(s_wr(10'd30, 32'h0000000B, 4'hF));
        tbl.push_back(s_wr(10'd31, 32'hC0000000, 4'hF));
        tbl.push_back(s_wr(10'h200, 32'h1, 4'hF));
        s = s_idle(); s.fs = 1'b1;
        tbl.push_back(s);
        for (int x = 0; x < 8; x++) tbl.push_back(s_pix(5'd0, 4'(x), 4'd0, 1'b0, 1'b0));
        tbl.push_back(s_rd(10'h200));
        for (int i = 0; i < tbl.size() + 4; i++) begin
            if (i < tbl.size()) apply(tbl[i]); else apply(s_idle());
            tick();
            if (pix_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL map_pix: unexpected pix_valid data=%h", pix_data);
                end else begin
                    e = pq.pop_front();
                    if ({pix_data, pix_opaque} !== {e.d, e.o} || cyc - e.c != 2) begin
                        errors++;
                        $display("FAIL map_pix: got %h/%b lat %0d, want %h/%b lat 2",
                                 pix_data, pix_opaque, cyc - e.c, e.d, e.o);
                    end
                end
            end
            if (readdatavalid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL map_rd: unexpected readdatavalid rd=%h", readdata);
                end else begin
                    r = rq.pop_front();
                    if (readdata !== r.d || cyc - r.c != 1) begin
                        errors++;
                        $display("FAIL map_rd: got %h lat %0d, want %h lat 1",
                                 readdata, cyc - r.c, r.d);
                    end
                end
            end
        end
        checks++;
        if (pq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL map_timeout: %0d pix %0d rd outstanding, want 0", pq.size(), rq.size());
            pq.delete(); rq.delete();
        end
    endtask

    task automatic test_mirror_range();
        stim_t tbl[$];
        pix_t  e;
        tbl.push_back(s_pix(5'd0,  4'd0, 4'd0, 1'b1, 1'b0));
        tbl.push_back(s_pix(5'd0,  4'd0, 4'd0, 1'b0, 1'b1));
        tbl.push_back(s_pix(5'd0,  4'd0, 4'd0, 1'b1, 1'b1));
        tbl.push_back(s_pix(5'd16, 4'd0, 4'd0, 1'b0, 1'b0));
        tbl.push_back(s_pix(5'd0,  4'd7, 4'd0, 1'b0, 1'b0));
        tbl.push_back(s_pix(5'd31, 4'd5, 4'd5, 1'b1, 1'b1));
        tbl.push_back(s_pix(5'd0,  4'd8, 4'd0, 1'b1, 1'b0));
        for (int i = 0; i < tbl.size() + 4; i++) begin
            if (i < tbl.size()) apply(tbl[i]); else apply(s_idle());
            tick();
            if (pix_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL mirror_pix: unexpected pix_valid data=%h", pix_data);
                end else begin
                    e = pq.pop_front();
                    if ({pix_data, pix_opaque} !== {e.d, e.o} || cyc - e.c != 2) begin
                        errors++;
                        $display("FAIL mirror_pix: got %h/%b lat %0d, want %h/%b lat 2",
                                 pix_data, pix_opaque, cyc - e.c, e.d, e.o);
                    end
                end
            end
        end
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL mirror_timeout: %0d pix outstanding, want 0", pq.size());
            pq.delete();
        end
    endtask

    task automatic test_byteenable();
        stim_t tbl[$];
        stim_t s;
        rd_t   r;
        tbl.push_back(s_wr(10'd5, 32'h00000000, 4'hF));
        tbl.push_back(s_wr(10'd5, 32'hFFFFFFFF, 4'b0010));
        tbl.push_back(s_rd(10'd5));
        tbl.push_back(s_wr(10'd7, 32'h00000000, 4'hF));
        tbl.push_back(s_wr(10'd7, 32'hDEADBEEF, 4'b1001));
        s = s_wr(10'd6, 32'h12345678, 4'hF); s.rd = 1'b1;
        tbl.push_back(s);
        tbl.push_back(s_rd(10'd6));
        tbl.push_back(s_rd(10'd7));
        tbl.push_back(s_rd(10'd5));
        for (int i = 0; i < tbl.size() + 3; i++) begin
            if (i < tbl.size()) apply(tbl[i]); else apply(s_idle());
            tick();
            if (readdatavalid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL be_rd: unexpected readdatavalid rd=%h", readdata);
                end else begin
                    r = rq.pop_front();
                    if (readdata !== r.d || cyc - r.c != 1) begin
                        errors++;
                        $display("FAIL be_rd: got %h lat %0d, want %h lat 1",
                                 readdata, cyc - r.c, r.d);
                    end
                end
            end
        end
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL be_timeout: %0d rd outstanding, want 0", rq.size());
            rq.delete();
        end
    endtask

    task automatic test_reset_flush();
        stim_t tbl[$];
        stim_t s;
        pix_t  e;
        tbl.push_back(s_pix(5'd0, 4'd1, 4'd0, 1'b0, 1'b0));
        s = s_pix(5'd0, 4'd2, 4'd0, 1'b0, 1'b0);
        s.rst = 1'b1; s.cs = 1'b1; s.rd = 1'b1; s.a = 10'h200;
        tbl.push_back(s);
        for (int i = 0; i < tbl.size() + 4; i++) begin
            if (i < tbl.size()) apply(tbl[i]); else apply(s_idle());
            tick();
            if (i == 1) begin
                checks++;
                if ({readdata, readdatavalid, pix_valid, pix_data, pix_opaque} !== 39'd0) begin
                    errors++;
                    $display("FAIL flush_outputs: rd=%h rdv=%b pv=%b pd=%h po=%b, want all 0",
                             readdata, readdatavalid, pix_valid, pix_data, pix_opaque);
                end
            end
            if (pix_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL flush_pix: unexpected pix_valid data=%h", pix_data);
                end else begin
                    e = pq.pop_front();
                    if ({pix_data, pix_opaque} !== {e.d, e.o} || cyc - e.c != 2) begin
                        errors++;
                        $display("FAIL flush_pix: got %h/%b lat %0d, want %h/%b lat 2",
                                 pix_data, pix_opaque, cyc - e.c, e.d, e.o);
                    end
                end
            end
            if (readdatavalid) begin
                checks++;
                errors++;
                $display("FAIL flush_rd: readdatavalid=1 rd=%h, want no response", readdata);
            end
        end
        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL flush_timeout: %0d pix outstanding, want 0", pq.size());
            pq.delete();
        end
    endtask

    task automatic test_csr_swap();
        stim_t tbl[$];
        stim_t s;
        pix_t  e;
        rd_t   r;
        tbl.push_back(s_wr(10'h200, 32'h1, 4'hF));
        tbl.push_back(s_rd(10'h200));
        tbl.push_back(s_pix(5'd0, 4'd10, 4'd2, 1'b0, 1'b0));
        s = s_pix(5'd0, 4'd11, 4'd2, 1'b0, 1'b0);
        s.fs = 1'b1; s.cs = 1'b1; s.wr = 1'b1; s.a = 10'd9; s.wd = 32'h00000050;
        tbl.push_back(s);
        tbl.push_back(s_pix(5'd0, 4'd3, 4'd0, 1'b0, 1'b0));
        tbl.push_back(s_pix(5'd0, 4'd9, 4'd4, 1'b0, 1'b0));
        tbl.push_back(s_rd(10'h200));
        s = s_wr(10'h3FF, 32'h1, 4'hF); s.fs = 1'b1;
        tbl.push_back(s);
        tbl.push_back(s_rd(10'h200));
        s = s_idle(); s.fs = 1'b1;
        tbl.push_back(s);
        tbl.push_back(s_rd(10'h200));
        tbl.push_back(s);
        tbl.push_back(s_rd(10'h200));
        tbl.push_back(s_wr(10'h200, 32'hFFFFFFFE, 4'hF));
        tbl.push_back(s_rd(10'h200));
        tbl.push_back(s_wr(10'h200, 32'h1, 4'hF));
        tbl.push_back(s_wr(10'h200, 32'h1, 4'hF));
        tbl.push_back(s_rd(10'h201));
        for (int i = 0; i < tbl.size() + 4; i++) begin
            if (i < tbl.size()) apply(tbl[i]); else apply(s_idle());
            tick();
            if (pix_valid) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL swap_pix: unexpected pix_valid data=%h", pix_data);
                end else begin
                    e = pq.pop_front();
                    if ({pix_data, pix_opaque} !== {e.d, e.o} || cyc - e.c != 2) begin
                        errors++;
                        $display("FAIL swap_pix: got %h/%b lat %0d, want %h/%b lat 2",
                                 pix_data, pix_opaque, cyc - e.c, e.d, e.o);
                    end
                end
            end
            if (readdatavalid) begin
                checks++;
                if (rq.size() == 0) begin
                    errors++;
                    $display("FAIL swap_rd: unexpected readdatavalid rd=%h", readdata);
                end else begin
                    r = rq.pop_front();
                    if (readdata !== r.d || cyc - r.c != 1) begin
                        errors++;
                        $display("FAIL swap_rd: got %h lat %0d, want %h lat 1",
                                 readdata, cyc - r.c, r.d);
                    end
                end
            end
        end
        checks++;
        if (pq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL swap_timeout: %0d pix %0d rd outstanding, want 0", pq.size(), rq.size());
            pq.delete(); rq.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        apply(s_idle());
        reset = 1'b1;
        test_reset();
        test_pixel_map();
        test_mirror_range();
        test_byteenable();
        test_reset_flush();
        test_csr_swap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
